t1_bank_resp_nr1wa: RTL
=======================

// Module: t1_bank_resp_nr1wa
// PURPOSE
//  Responder end of the t1 bank interface driven by the nR1W duplicated-bank core: NUMRDPT*NUMVBNK physical banks.
//  Each bank has write port A (bit-masked) and read port B returning data SRAM_DELAY cycles after the request.
//  Used as the synthesizable/formal stand-in for macro SRAMs under the algo wrapper, plus optional protocol checks.
// PARAMETERS
//  WIDTH      32    data bits per bank word
//  NUMRDPT    4     read ports (one bank copy per port)
//  NUMVBNK    8     virtual banks per copy
//  NUMVROW    1024  rows per bank
//  BITVROW    10    row address width, clog2(NUMVROW)
//  SRAM_DELAY 2     read latency in cycles, legal range 1..8
// PORTS
//  clk        in   1                       single clock, all logic on posedge
//  rst        in   1                       synchronous, active-high reset
//  t1_writeA  in   NUMRDPT*NUMVBNK         per-bank write enable
//  t1_addrA   in   NUMRDPT*NUMVBNK*BITVROW per-bank write row
//  t1_bwA     in   NUMRDPT*NUMVBNK*WIDTH   per-bank bit-write mask, 1 = write bit
//  t1_dinA    in   NUMRDPT*NUMVBNK*WIDTH   per-bank write data
//  t1_readB   in   NUMRDPT*NUMVBNK         per-bank read enable
//  t1_addrB   in   NUMRDPT*NUMVBNK*BITVROW per-bank read row
//  t1_doutB   out  NUMRDPT*NUMVBNK*WIDTH   per-bank read data
//  t1_err     out  2                       sticky errors [0]=out-of-range address, [1]=same-row A/B collision
// BEHAVIOUR
//  - Bank b occupies slice b of every bus; b = port*NUMVBNK + vbnk.
//  - Write: if t1_writeA[b] and addrA<NUMVROW: mem[b][addrA] <= (old & ~bwA) | (dinA & bwA), visible next cycle.
//  - Read: request in cycle T captures mem[b][addrB] at T (read-before-write: same-cycle write to same row NOT seen).
//  - Data pipelined through SRAM_DELAY-1 further stages; t1_doutB[b] updates exactly at T+SRAM_DELAY.
//  - No read in cycle T: stage at T+SRAM_DELAY keeps prior value (output holds last read data, SRAM-like).
//  - Back-to-back reads every cycle: one result per cycle, in order, no bubbles.
//  - addrA >= NUMVROW: write dropped; addrB >= NUMVROW: returns all-zero data at normal latency.
//  - Reset: t1_doutB=0, all pipeline valid bits=0, t1_err=0; memory array is NOT reset (contents retained).
//  - Reads in flight when rst asserts are discarded; first post-reset read returns at normal latency.
//  - t1_err bits set on the detecting cycle, registered (visible next cycle), cleared only by rst.
// CONFIGURATION
//  - Macro T1_RESP_CHECK_EN defined: t1_err[0] set on any enabled access with row >= NUMVROW;
//    t1_err[1] set when t1_writeA[b] & t1_readB[b] & addrA==addrB (legal, but flags possible core bug).
//  - Macro undefined: check logic absent, t1_err tied to 2'b00; datapath behaviour identical.
// STRUCTURE
//  - Shared package t1_resp_pkg: localparam NUMBNK=NUMRDPT*NUMVBNK, typedefs row_t [BITVROW-1:0], word_t [WIDTH-1:0],
//    err index constants ERR_OOR=0, ERR_COLL=1.
//  - One sub-module t1_bank_1r1w: single bank, array + read capture + SRAM_DELAY pipeline; top generates NUMBNK
//    instances and ORs per-bank error pulses into t1_err.
// TESTING
//  - Reset, write bank0 row5 din=32'hA5A5_A5A5 bw=all1s, read row5 next cycle -> doutB[0]=A5A5_A5A5 exactly 2 cycles after read.
//  - Partial write row5 bw=32'h0000_FFFF din=32'h1234_5678 -> subsequent read = 32'hA5A5_5678.
//  - Same-cycle write row9 din=1 and read row9 (old=0) -> read returns 0; next read returns 1; t1_err[1]=1 with macro, 0 without.
//  - Reads rows 0,1,2,3 on bank 31 in consecutive cycles (pre-written 10..13) -> doutB[31] = 10,11,12,13 on consecutive cycles, holds 13 after.
//  - Read row 1023 then addrB=NUMVROW via 11-bit override/NUMVROW=1000 build -> zero data, t1_err[0]=1 with macro.
//  - rst asserted one cycle after a read -> doutB=0 after reset, stale result never appears; memory contents preserved on re-read.

Source files
------------

// File: rtl/t1_resp_pkg.sv
// Shared definitions for the t1 bank responder: bus geometry, row/word
// types, error-bit positions and a row range helper.
package t1_resp_pkg;

  localparam int WIDTH   = 32;                // data bits per bank word
  localparam int NUMRDPT = 4;                 // read ports, one bank copy each
  localparam int NUMVBNK = 8;                 // virtual banks per copy
  localparam int NUMBNK  = NUMRDPT * NUMVBNK; // physical banks on the bus
  localparam int BITVROW = 10;                // row address width

  // Bit positions inside t1_err
  localparam int ERR_OOR  = 0;  // access to a row beyond the array
  localparam int ERR_COLL = 1;  // write and read of the same row in one cycle

  typedef logic [BITVROW-1:0] row_t;
  typedef logic [WIDTH-1:0]   word_t;

  // True when the row addresses a physical entry of an nrow-deep array
  function automatic logic row_in_range(input row_t row, input int unsigned nrow);
    return 32'(row) < nrow;
  endfunction

endpackage

// File: rtl/t1_bank_resp_nr1wa_if.sv
// Flat per-bank t1 bus between the nR1W core (master) and the bank
// responder (slave). Bank b occupies slice b of every field.
interface t1_bank_resp_nr1wa_if
  import t1_resp_pkg::*;
();

  logic [NUMBNK-1:0]         t1_writeA;
  logic [NUMBNK*BITVROW-1:0] t1_addrA;
  logic [NUMBNK*WIDTH-1:0]   t1_bwA;
  logic [NUMBNK*WIDTH-1:0]   t1_dinA;
  logic [NUMBNK-1:0]         t1_readB;
  logic [NUMBNK*BITVROW-1:0] t1_addrB;
  logic [NUMBNK*WIDTH-1:0]   t1_doutB;

  modport master (
    output t1_writeA, t1_addrA, t1_bwA, t1_dinA, t1_readB, t1_addrB,
    input  t1_doutB
  );

  modport slave (
    input  t1_writeA, t1_addrA, t1_bwA, t1_dinA, t1_readB, t1_addrB,
    output t1_doutB
  );

endinterface

// File: rtl/t1_bank_1r1w.sv
// One physical bank: bit-masked write port A, read port B with
// SRAM_DELAY-cycle latency and read-before-write on a same-row access.
// Optional protocol checks are compiled in with T1_RESP_CHECK_EN.
module t1_bank_1r1w
  import t1_resp_pkg::*;
#(
  parameter int NUMVROW    = 1024,
  parameter int SRAM_DELAY = 2      // legal range 1..8
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  wr_en,
  input  row_t  wr_row,
  input  word_t wr_mask,
  input  word_t wr_data,
  input  logic  rd_en,
  input  row_t  rd_row,
  output word_t rd_data,
  output logic  oor_pulse,
  output logic  coll_pulse
);

  word_t mem [NUMVROW];
  logic  wr_ok;
  logic  rd_ok;
  word_t cap_data;
  logic  last_vld;
  word_t last_data;

  assign wr_ok = row_in_range(wr_row, NUMVROW);
  assign rd_ok = row_in_range(rd_row, NUMVROW);

  // Array write: merge masked bits of the new data into the stored word.
  // NOTE: the array has no reset branch on purpose; contents survive rst like a real macro.
  // NOTE: non-blocking update means a same-edge read below still sees the old word.
  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) begin
      mem[wr_row] <= (mem[wr_row] & ~wr_mask) | (wr_data & wr_mask);
    end
  end

  // Rows past the array read back as zero
  assign cap_data = rd_ok ? mem[rd_row] : '0;

  if (SRAM_DELAY == 1) begin : g_nopipe
    assign last_vld  = rd_en;
    assign last_data = cap_data;
  end else begin : g_pipe
    logic [SRAM_DELAY-2:0] vld_q;
    word_t                 data_q [SRAM_DELAY-1];

    // Valid bits track requests in flight; cleared so reset drops them
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= rd_en;
        for (int i = 1; i < SRAM_DELAY - 1; i++) begin
          vld_q[i] <= vld_q[i-1];
        end
      end
    end

    // Data stages move only with a valid request behind them
    always_ff @(posedge clk) begin
      if (rd_en) data_q[0] <= cap_data;
      for (int i = 1; i < SRAM_DELAY - 1; i++) begin
        if (vld_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end

    assign last_vld  = vld_q[SRAM_DELAY-2];
    assign last_data = data_q[SRAM_DELAY-2];
  end

  // Output stage holds the last returned word between reads
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (last_vld) begin
      rd_data <= last_data;
    end
  end

`ifdef T1_RESP_CHECK_EN
  assign oor_pulse  = (wr_en && !wr_ok) || (rd_en && !rd_ok);
  assign coll_pulse = wr_en && rd_en && (wr_row == rd_row);
`else
  assign oor_pulse  = 1'b0;
  assign coll_pulse = 1'b0;
`endif

endmodule

// File: rtl/t1_bank_resp_nr1wa.sv
// Responder end of the t1 bank interface for the nR1W duplicated-bank core:
// NUMBNK independent 1R1W banks plus sticky protocol error flags.
// Build option: define T1_RESP_CHECK_EN to compile in the t1_err checks;
// without it t1_err stays 2'b00 and the datapath is unchanged.
module t1_bank_resp_nr1wa
  import t1_resp_pkg::*;
#(
  parameter int NUMVROW    = 1024,
  parameter int SRAM_DELAY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  t1_bank_resp_nr1wa_if.slave  t1,
  output logic [1:0]           t1_err
);

  word_t             dout_w [NUMBNK];
  logic [NUMBNK-1:0] oor_pulse;
  logic [NUMBNK-1:0] coll_pulse;

  for (genvar b = 0; b < NUMBNK; b++) begin : g_bank
    t1_bank_1r1w #(
      .NUMVROW    (NUMVROW),
      .SRAM_DELAY (SRAM_DELAY)
    ) u_bank (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (t1.t1_writeA[b]),
      .wr_row     (t1.t1_addrA[b*BITVROW +: BITVROW]),
      .wr_mask    (t1.t1_bwA[b*WIDTH +: WIDTH]),
      .wr_data    (t1.t1_dinA[b*WIDTH +: WIDTH]),
      .rd_en      (t1.t1_readB[b]),
      .rd_row     (t1.t1_addrB[b*BITVROW +: BITVROW]),
      .rd_data    (dout_w[b]),
      .oor_pulse  (oor_pulse[b]),
      .coll_pulse (coll_pulse[b])
    );
    assign t1.t1_doutB[b*WIDTH +: WIDTH] = dout_w[b];
  end

`ifdef T1_RESP_CHECK_EN
  logic [1:0] err_q;

  // Sticky error flags: set the edge after detection, cleared only by rst
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      if (|oor_pulse)  err_q[ERR_OOR]  <= 1'b1;
      if (|coll_pulse) err_q[ERR_COLL] <= 1'b1;
    end
  end

  assign t1_err = err_q;
`else
  // Per-bank pulses are constant zero in this build, so t1_err is tied low
  assign t1_err[ERR_OOR]  = |oor_pulse;
  assign t1_err[ERR_COLL] = |coll_pulse;
`endif

endmodule
